leaf_rom_arbiter: RTL and testbench
===================================

// Module: leaf_rom_arbiter
// PURPOSE
//  Shares one leaf-value ROM read port (dti addr out / dti data in) between N_REQ classifier-stage requesters.
//  - Round-robin grant on the address channel.
//  - Per-request requester ID is queued in an in-flight FIFO, so read data returns to the issuing requester in order.
//  - Sits between the stage evaluators and one leafVal memory instance.
// PARAMETERS
//  N_REQ       2     number of requesters (2..8)
//  W_ADDR      16    ROM address width
//  W_DATA      16    ROM data width
//  MAX_OUTST   4     max reads in flight (ID FIFO depth, power of 2, >=2)
// PORTS
//  clk          in   1             clock
//  rst          in   1             synchronous active-high reset
//  req_valid    in   N_REQ         per-requester address valid
//  req_ready    out  N_REQ         per-requester address accepted
//  req_addr     in   N_REQ*W_ADDR  packed addresses, requester i at [i*W_ADDR +: W_ADDR]
//  rsp_valid    out  N_REQ         per-requester read data valid
//  rsp_ready    in   N_REQ         per-requester read data accept
//  rsp_data     out  W_DATA        read data, broadcast; qualified by rsp_valid
//  rom_addr_if  dti.producer W_ADDR  address channel to ROM read port
//  rom_data_if  dti.consumer W_DATA  data channel from ROM read port
// BEHAVIOUR
//  - Reset: rr_ptr=0, FIFO empty (count=0), req_ready=0, rsp_valid=0, rom_addr_if.valid=0, rom_data_if.ready=0.
//  - Reset is honoured mid-operation: in-flight IDs are discarded. Any ROM data arriving afterwards is dropped
//    (ready=0 while FIFO empty).
//  - Grant logic is combinational:
//      eligible = |req_valid && !fifo_full.
//      grant = first i with req_valid[i], searching rr_ptr, rr_ptr+1, ... modulo N_REQ.
//  - Address channel, when eligible:
//      rom_addr_if.valid=1, rom_addr_if.data=req_addr[grant].
//      req_ready[grant]=rom_addr_if.ready; all other req_ready=0.
//      Address path latency is zero cycles (pass-through).
//  - On an address handshake:
//      push grant ID into FIFO.
//      rr_ptr <= (grant==N_REQ-1) ? 0 : grant+1.
//  - No handshake: rr_ptr holds, so a stalled grant is never reassigned while the ROM is not ready.
//  - Full FIFO (count==MAX_OUTST): no grant and rom_addr_if.valid=0, even if a pop happens in the same cycle
//    (push gating uses the registered count only).
//  - Data channel, head = FIFO head ID:
//      rsp_valid[head]=rom_data_if.valid && !fifo_empty.
//      rom_data_if.ready=rsp_ready[head] && !fifo_empty.
//      rsp_data=rom_data_if.data.
//      On data handshake, pop.
//  - Simultaneous push and pop with FIFO not full: count unchanged, both pointers advance.
//  - Pointers wrap modulo MAX_OUTST.
//  - rom_data_if.valid while FIFO empty is a protocol error. Behaviour: data held unaccepted. A simulation
//    assertion fires.
//  - Requester de-asserting req_valid before its handshake is legal. Grant moves to the next eligible requester
//    in the same cycle.
//  - The ROM read port must return data in request order. The arbiter adds no reordering and no data latency.
// CONFIGURATION
//  LEAF_ARB_STATS_EN defined:
//    - Adds output grant_cnt (N_REQ*16): per-requester saturating count of address handshakes.
//    - Reset to 0; sticks at 16'hFFFF.
//    - Adds output stall_cnt (16): cycles with |req_valid && !rom_addr_if.ready or FIFO full. Saturating.
//  LEAF_ARB_STATS_EN undefined:
//    - Those ports and counters do not exist.
//    - Functional behaviour is identical.
// STRUCTURE
//  - Package leaf_arb_pkg:
//      ID_W = $clog2(N_REQ) helper function.
//      CNT_W helper for MAX_OUTST.
//      typedef req_id_t (logic [2:0], max 8 requesters).
//      STAT_W=16 constant.
//  - Sub-module leaf_arb_id_fifo: synchronous FIFO of req_id_t.
//      Depth MAX_OUTST; push/pop/full/empty/head; count register.
//  - Top: round-robin grant function, rr_ptr register, channel muxing, optional stats block.
// TESTING
//  1. Reset: assert rst 3 cycles with req_valid=2'b11 -> req_ready=0, rsp_valid=0, rom_addr_if.valid=0 throughout.
//  2. Single requester, N_REQ=2, ROM always ready, 1-cycle latency:
//       req0 addr 0x0010,0x0011,0x0012 back-to-back -> 3 grants to req0, data D(0x10..0x12) on rsp_valid[0] in order.
//       rsp_valid[1] stays 0.
//  3. Contention: req_valid=2'b11 held 6 cycles -> grants alternate 0,1,0,1,0,1.
//       Each rsp_data pairs with the issuing requester.
//  4. Back-pressure:
//       a. rom_data_if.valid held with rsp_ready[0]=0, MAX_OUTST=4 -> after 4 address handshakes,
//          rom_addr_if.valid=0 until one pop.
//       b. Pop and new request in the same cycle when full -> push occurs next cycle.
//  5. ROM stall: rom_addr_if.ready=0 for 5 cycles with req1 granted (rr_ptr=1) and req0 also valid
//       -> grant stays on req1; rr_ptr unchanged; req1 handshakes first when ready rises.
//  6. Mid-flight reset: 2 outstanding reads, pulse rst 1 cycle -> FIFO empty.
//       Late ROM data not accepted and not routed to any rsp_valid.
//       With LEAF_ARB_STATS_EN, grant_cnt=0 after reset.

Source files
------------

// File: rtl/leaf_arb_pkg.sv
// Shared types and sizing helpers for the leaf-value ROM arbiter.
// Optional stats counters are enabled by defining LEAF_ARB_STATS_EN.
package leaf_arb_pkg;

  localparam int STAT_W = 16;

  typedef logic [2:0] req_id_t;

  function automatic int id_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/dti.sv
// Valid/ready data-transfer interface used for the ROM read port.
// Producer drives valid/data, consumer drives ready.
interface dti #(
  parameter int W = 16
);
  logic         valid;
  logic         ready;
  logic [W-1:0] data;

  modport producer (output valid, output data, input ready);
  modport consumer (input valid, input data, output ready);
endinterface

// File: rtl/leaf_arb_id_fifo.sv
// In-flight requester-ID FIFO; head is the requester owed the next ROM word.
// Depth must be a power of two so the pointers wrap naturally.
module leaf_arb_id_fifo
  import leaf_arb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    i_push,
  input  logic    i_pop,
  input  req_id_t i_din,
  output req_id_t o_head,
  output logic    o_full,
  output logic    o_empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  req_id_t        r_mem [DEPTH];
  logic [PW-1:0]  r_wptr;
  logic [PW-1:0]  r_rptr;
  logic [CW-1:0]  r_count;

  always_ff @(posedge clk) begin
    if (i_push) begin
      r_mem[r_wptr] <= i_din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + PW'(1);
      if (i_pop)  r_rptr <= r_rptr + PW'(1);
      unique case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rptr];
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);

endmodule

// File: rtl/leaf_rom_arbiter.sv
// Round-robin share of one leaf-value ROM read port among N_REQ requesters.
// Define LEAF_ARB_STATS_EN to add grant_cnt/stall_cnt saturating counters.
module leaf_rom_arbiter
  import leaf_arb_pkg::*;
#(
  parameter int N_REQ     = 2,
  parameter int W_ADDR    = 16,
  parameter int W_DATA    = 16,
  parameter int MAX_OUTST = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ*W_ADDR-1:0] req_addr,
  output logic [N_REQ-1:0]        rsp_valid,
  input  logic [N_REQ-1:0]        rsp_ready,
  output logic [W_DATA-1:0]       rsp_data,
  dti.producer                    rom_addr_if,
  dti.consumer                    rom_data_if
`ifdef LEAF_ARB_STATS_EN
  ,
  output logic [N_REQ*STAT_W-1:0] grant_cnt,
  output logic [STAT_W-1:0]       stall_cnt
`endif
);

  localparam logic [N_REQ-1:0] ONE = 1;

  req_id_t r_rr_ptr;
  req_id_t w_grant;
  req_id_t w_head;
  logic    w_any;
  logic    w_eligible;
  logic    w_push;
  logic    w_pop;
  logic    w_full;
  logic    w_empty;
  logic    w_head_rdy;

  function automatic req_id_t rr_pick(
    input logic [N_REQ-1:0] v,
    input req_id_t          ptr
  );
    req_id_t          g;
    logic             found;
    logic [N_REQ-1:0] sh;
    int               j;
    g     = '0;
    found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      j = int'(ptr) + k;
      if (j >= N_REQ) j = j - N_REQ;
      sh = v >> j;
      if (!found && sh[0]) begin
        g     = req_id_t'(j);
        found = 1'b1;
      end
    end
    return g;
  endfunction

  assign w_grant    = rr_pick(req_valid, r_rr_ptr);
  assign w_any      = |req_valid;
  // Full gating uses the registered count only, never a same-cycle pop.
  assign w_eligible = w_any && !w_full && !rst;
  assign w_push     = w_eligible && rom_addr_if.ready;

  assign rom_addr_if.valid = w_eligible;
  assign rom_addr_if.data  = req_addr[int'(w_grant)*W_ADDR +: W_ADDR];
  assign req_ready = w_push ? (ONE << w_grant) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr <= '0;
    end else if (w_push) begin
      r_rr_ptr <= (w_grant == req_id_t'(N_REQ - 1)) ? '0 : w_grant + 3'd1;
    end
  end

  leaf_arb_id_fifo #(
    .DEPTH (MAX_OUTST)
  ) u_id_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   (w_grant),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_head_rdy        = |(rsp_ready & (ONE << w_head));
  assign rom_data_if.ready = w_head_rdy && !w_empty && !rst;
  assign w_pop             = rom_data_if.valid && rom_data_if.ready;
  assign rsp_valid = (rom_data_if.valid && !w_empty && !rst) ? (ONE << w_head) : '0;
  assign rsp_data  = rom_data_if.data;

`ifndef SYNTHESIS
  a_no_data_when_empty: assert property (
    @(posedge clk) disable iff (rst) !(rom_data_if.valid && w_empty)
  );
`endif

`ifdef LEAF_ARB_STATS_EN
  logic [STAT_W-1:0] r_gcnt [N_REQ];
  logic [STAT_W-1:0] r_stall;
  logic              w_stall;

  assign w_stall = (w_any && !rom_addr_if.ready) || w_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_REQ; i++) r_gcnt[i] <= '0;
      r_stall <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (w_push && w_grant == req_id_t'(i) && r_gcnt[i] != '1)
          r_gcnt[i] <= r_gcnt[i] + STAT_W'(1);
      end
      if (w_stall && r_stall != '1) r_stall <= r_stall + STAT_W'(1);
    end
  end

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_gcnt
    assign grant_cnt[gi*STAT_W +: STAT_W] = r_gcnt[gi];
  end
  assign stall_cnt = r_stall;
`endif

endmodule

// File: tb/tb_leaf_rom_arbiter.sv
// Self-checking bench: grant table, ROM stub with scoreboard, corner sequences.
// Build with LEAF_ARB_STATS_EN defined to also exercise the stats counters.
module tb_leaf_rom_arbiter;
  import leaf_arb_pkg::*;

  localparam int N  = 2;
  localparam int WA = 16;
  localparam int WD = 16;
  localparam int MO = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req_valid;
  logic [N-1:0]  req_ready;
  logic [N*WA-1:0] req_addr;
  logic [N-1:0]  rsp_valid;
  logic [N-1:0]  rsp_ready;
  logic [WD-1:0] rsp_data;
`ifdef LEAF_ARB_STATS_EN
  logic [N*16-1:0] grant_cnt;
  logic [15:0]     stall_cnt;
`endif

  dti #(.W(WA)) a_if ();
  dti #(.W(WD)) d_if ();

  always #5 clk = ~clk;

  leaf_rom_arbiter #(
    .N_REQ     (N),
    .W_ADDR    (WA),
    .W_DATA    (WD),
    .MAX_OUTST (MO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .rom_addr_if (a_if),
    .rom_data_if (d_if)
`ifdef LEAF_ARB_STATS_EN
    ,
    .grant_cnt   (grant_cnt),
    .stall_cnt   (stall_cnt)
`endif
  );

  typedef struct {
    logic [2:0]  id;
    logic [15:0] data;
  } exp_t;

  typedef struct {
    logic [1:0]  rv;
    logic        ev;
    logic [15:0] ea;
  } vec_t;

  exp_t        exp_q [$];
  logic [15:0] romq  [$];
  int          total = 0;
  int          bad   = 0;
  int          n_rsp = 0;
  bit          dv_en = 1'b1;
  int          g_grant;
  bit          g_hs_a;
  bit          g_hs_d;
  bit          g_av;
  logic [15:0] g_addr;

  function automatic logic [15:0] dfun(input logic [15:0] a);
    return a ^ 16'h5A3C;
  endfunction

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // One clock: sample handshakes mid-cycle, then let the ROM stub respond.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    g_av    = a_if.valid;
    g_addr  = a_if.data;
    g_hs_a  = a_if.valid && a_if.ready;
    g_hs_d  = d_if.valid && d_if.ready;
    g_grant = -1;
    if (g_hs_d) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rsp_unexpected: got rsp_valid %b want none", rsp_valid);
      end else begin
        e = exp_q.pop_front();
        check("rsp_route", 32'(rsp_valid), 32'(1) << e.id);
        check("rsp_data", 32'(rsp_data), 32'(e.data));
        n_rsp++;
      end
      if (romq.size() > 0) void'(romq.pop_front());
    end
    if (g_hs_a) begin
      check("grant_ready", 32'(req_ready), 32'(1) << g_addr[12]);
      g_grant = int'(g_addr[12]);
      romq.push_back(dfun(g_addr));
      exp_q.push_back('{id: 3'(g_addr[12]), data: dfun(g_addr)});
    end
    @(posedge clk);
    #1;
    d_if.valid = dv_en && (romq.size() > 0);
    d_if.data  = (romq.size() > 0) ? romq[0] : 16'h0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) tick();
    check("drain_left", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl [5];
    int   eg  [6];
    int   nh;
    int   base;

    rst        = 1'b1;
    req_valid  = 2'b11;
    req_addr   = {16'h1000, 16'h0000};
    rsp_ready  = 2'b00;
    a_if.ready = 1'b1;
    d_if.valid = 1'b0;
    d_if.data  = '0;

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_req_ready", 32'(req_ready), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_addr_valid", 32'(a_if.valid), 32'd0);
      check("rst_data_ready", 32'(d_if.ready), 32'd0);
      @(posedge clk);
      #1;
    end
    rst       = 1'b0;
    req_valid = 2'b00;
`ifdef LEAF_ARB_STATS_EN
    check("rst_grant_cnt", grant_cnt, 32'd0);
    check("rst_stall_cnt", 32'(stall_cnt), 32'd0);
`endif

    tbl[0] = '{rv: 2'b00, ev: 1'b0, ea: 16'h0000};
    tbl[1] = '{rv: 2'b01, ev: 1'b1, ea: 16'h0010};
    tbl[2] = '{rv: 2'b10, ev: 1'b1, ea: 16'h1020};
    tbl[3] = '{rv: 2'b11, ev: 1'b1, ea: 16'h0010};
    tbl[4] = '{rv: 2'b00, ev: 1'b0, ea: 16'h0000};
    a_if.ready = 1'b0;
    req_addr   = {16'h1020, 16'h0010};
    for (int i = 0; i < 5; i++) begin
      req_valid = tbl[i].rv;
      #2;
      check("tbl_addr_valid", 32'(a_if.valid), 32'(tbl[i].ev));
      if (tbl[i].ev) check("tbl_addr", 32'(a_if.data), 32'(tbl[i].ea));
      check("tbl_req_ready", 32'(req_ready), 32'd0);
      @(posedge clk);
      #1;
    end

    a_if.ready = 1'b1;
    rsp_ready  = 2'b11;
    base       = n_rsp;
    req_valid  = 2'b01;
    for (int k = 0; k < 3; k++) begin
      req_addr[15:0] = 16'h0010 + 16'(k);
      tick();
      check("single_hs", 32'(g_hs_a), 32'd1);
      check("single_grant", 32'(g_grant), 32'd0);
    end
    req_valid = 2'b00;
    drain();
    check("single_rsps", 32'(n_rsp - base), 32'd3);
`ifdef LEAF_ARB_STATS_EN
    check("single_grant_cnt", grant_cnt, {16'd0, 16'd3});
`endif

    reset_pulse();
    eg        = '{0, 1, 0, 1, 0, 1};
    base      = n_rsp;
    req_addr  = {16'h1040, 16'h0040};
    req_valid = 2'b11;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("rr_hs", 32'(g_hs_a), 32'd1);
      check("rr_grant", 32'(g_grant), 32'(eg[i]));
    end
    req_valid = 2'b00;
    drain();
    check("rr_rsps", 32'(n_rsp - base), 32'd6);

    reset_pulse();
    rsp_ready      = 2'b00;
    req_addr[15:0] = 16'h0050;
    req_valid      = 2'b01;
    nh             = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      nh += int'(g_hs_a);
    end
    check("full_pushes", 32'(nh), 32'd4);
    check("full_addr_valid", 32'(g_av), 32'd0);
    check("full_rsp_head", 32'(rsp_valid), 32'b01);
    rsp_ready = 2'b01;
    tick();
    check("full_pop", 32'(g_hs_d), 32'd1);
    check("full_pop_addr_valid", 32'(g_av), 32'd0);
    check("full_pop_no_push", 32'(g_hs_a), 32'd0);
    rsp_ready = 2'b00;
    tick();
    check("full_push_next", 32'(g_hs_a), 32'd1);
    rsp_ready = 2'b11;
    req_valid = 2'b00;
    drain();

    reset_pulse();
    req_addr  = {16'h1060, 16'h0060};
    req_valid = 2'b01;
    tick();
    check("stall_pre_grant", 32'(g_grant), 32'd0);
    a_if.ready = 1'b0;
    req_valid  = 2'b11;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_no_hs", 32'(g_hs_a), 32'd0);
      check("stall_addr", 32'(g_addr), 32'h1060);
    end
    a_if.ready = 1'b1;
    tick();
    check("stall_release_hs", 32'(g_hs_a), 32'd1);
    check("stall_release_grant", 32'(g_grant), 32'd1);
    tick();
    check("stall_next_grant", 32'(g_grant), 32'd0);
    req_valid = 2'b00;
    drain();
`ifdef LEAF_ARB_STATS_EN
    check("stall_cnt_ge5", 32'(stall_cnt >= 16'd5), 32'd1);
`endif

    dv_en          = 1'b0;
    req_addr[15:0] = 16'h0070;
    req_valid      = 2'b01;
    tick();
    check("mid_hs0", 32'(g_hs_a), 32'd1);
    tick();
    check("mid_hs1", 32'(g_hs_a), 32'd1);
    req_valid  = 2'b00;
    rst        = 1'b1;
    d_if.valid = 1'b1;
    d_if.data  = romq[0];
    #2;
    check("mid_rst_data_ready", 32'(d_if.ready), 32'd0);
    check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    tick();
    check("mid_rst_no_pop", 32'(g_hs_d), 32'd0);
    rst        = 1'b0;
    romq.delete();
    exp_q.delete();
    d_if.valid = 1'b0;
    #2;
    check("mid_post_data_ready", 32'(d_if.ready), 32'd0);
    check("mid_post_rsp_valid", 32'(rsp_valid), 32'd0);
`ifdef LEAF_ARB_STATS_EN
    check("mid_grant_cnt", grant_cnt, 32'd0);
`endif
    rsp_ready = 2'b00;
    req_valid = 2'b01;
    nh        = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      nh += int'(g_hs_a);
    end
    check("mid_fifo_empty", 32'(nh), 32'd4);
    req_valid = 2'b00;
    rsp_ready = 2'b11;
    dv_en     = 1'b1;
    d_if.valid = (romq.size() > 0);
    d_if.data  = (romq.size() > 0) ? romq[0] : 16'h0;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
